// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings, fault causes and monitor states shared by the lamp safety monitor
package traffic_pkg;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_DARK   = 3'b000;

    localparam logic [11:0] ALL_RED  = {4{LT_RED}};
    localparam logic [11:0] ALL_DARK = {4{LT_DARK}};

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CODE     = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_TRANS    = 3'd3;
    localparam logic [2:0] FC_SHORT_G  = 3'd4;
    localparam logic [2:0] FC_SHORT_Y  = 3'd5;

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_PASS,
        ST_FAULT
    } mon_state_t;

endpackage

// File: rtl/tl_dir_check.sv
// tl_dir_check: per-direction code legality and transition classification
module tl_dir_check
    import traffic_pkg::*;
(
    input  logic [2:0] cur,
    input  logic [2:0] prev,
    output logic       bad_code,
    output logic       non_red,
    output logic       bad_trans,
    output logic       g2y,
    output logic       y2r
);

    assign bad_code  = !(cur == LT_GREEN || cur == LT_YELLOW || cur == LT_RED);
    assign non_red   = cur != LT_RED;
    assign g2y       = prev == LT_GREEN && cur == LT_YELLOW;
    assign y2r       = prev == LT_YELLOW && cur == LT_RED;
    assign bad_trans = cur != prev && !(prev == LT_RED && cur == LT_GREEN) && !g2y && !y2r;

endmodule

// File: rtl/traffic_lamp_safety_monitor.sv
// traffic_lamp_safety_monitor: vets controller light codes and drives lamps, flashing red on a latched fault
module traffic_lamp_safety_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 8,
    parameter int MIN_YELLOW  = 4,
    parameter int BLINK_HALF  = 16,
    parameter int STARTUP_CYC = 4,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_lights_in,
    input  logic [2:0] s_lights_in,
    input  logic [2:0] e_lights_in,
    input  logic [2:0] w_lights_in,
    input  logic       fault_clr,
    output logic [2:0] n_lamp,
    output logic [2:0] s_lamp,
    output logic [2:0] e_lamp,
    output logic [2:0] w_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BLINK_HALF - 1);

    logic [11:0]      in_q, prev_q, lamp_q;
    logic [CNT_W-1:0] dwell, st_cnt, blink_cnt;
    logic             dwell_ok;
    mon_state_t       state;
    logic [3:0]       bad_code, non_red, bad_trans, g2y, y2r;
    logic             chg, c_conf, legal, leave;
    logic [2:0]       cause_su, cause;

    for (genvar i = 0; i < 4; i++) begin : g_dir
        tl_dir_check u_chk (
            .cur      (in_q[3*i+:3]),
            .prev     (prev_q[3*i+:3]),
            .bad_code (bad_code[i]),
            .non_red  (non_red[i]),
            .bad_trans(bad_trans[i]),
            .g2y      (g2y[i]),
            .y2r      (y2r[i])
        );
    end

    assign chg      = in_q != prev_q;
    assign c_conf   = (non_red & (non_red - 4'd1)) != 4'd0;
    assign legal    = !(|bad_code) && !c_conf;
    assign leave    = state == ST_FAULT && fault_clr && legal;
    assign cause_su = |bad_code ? FC_CODE : c_conf ? FC_CONFLICT : FC_NONE;
    assign cause    = cause_su != FC_NONE ? cause_su :
                      |bad_trans ? FC_TRANS :
                      (dwell_ok && |g2y && dwell < MIN_G) ? FC_SHORT_G :
                      (dwell_ok && |y2r && dwell < MIN_Y) ? FC_SHORT_Y : FC_NONE;

    assign {n_lamp, s_lamp, e_lamp, w_lamp} = lamp_q;

    // input capture and dwell tracking; the first change after startup only arms the dwell checks
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            in_q     <= ALL_RED;
            prev_q   <= ALL_RED;
            dwell    <= '0;
            dwell_ok <= 1'b0;
        end else begin
            in_q     <= {n_lights_in, s_lights_in, e_lights_in, w_lights_in};
            prev_q   <= in_q;
            dwell    <= chg ? CNT_W'(1) : (dwell == CNT_MAX ? dwell : dwell + 1'b1);
            dwell_ok <= !leave && (dwell_ok || chg);
        end
    end

    // monitor FSM: startup hold, pass-through, and latched fault with red/dark flashing
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state      <= ST_STARTUP;
            lamp_q     <= ALL_RED;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            st_cnt     <= '0;
            blink_cnt  <= '0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    lamp_q <= ALL_RED;
                    if (!legal) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= cause_su;
                        blink_cnt  <= '0;
                    end else if (st_cnt == ST_LAST) begin
                        state  <= ST_PASS;
                        st_cnt <= '0;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                ST_PASS: begin
                    if (cause != FC_NONE) begin
                        state      <= ST_FAULT;
                        lamp_q     <= ALL_RED;
                        fault      <= 1'b1;
                        fault_code <= cause;
                        blink_cnt  <= '0;
                    end else begin
                        lamp_q <= in_q;
                    end
                end
                ST_FAULT: begin
                    if (leave) begin
                        state      <= ST_STARTUP;
                        lamp_q     <= ALL_RED;
                        fault      <= 1'b0;
                        fault_code <= FC_NONE;
                        st_cnt     <= '0;
                    end else if (blink_cnt == BL_LAST) begin
                        blink_cnt <= '0;
                        lamp_q    <= lamp_q == ALL_RED ? ALL_DARK : ALL_RED;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

endmodule
